sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
- Sits between the MEM stage of the ARM pipeline and the external 32-bit SRAM (17-bit word address, active-low write enable, shared bidirectional data bus).
- Converts single-cycle byte-addressed load/store requests into multi-cycle SRAM accesses.
- Holds the pipeline via ready while an access is in flight.
- Returns load data registered, stable for the release cycle.

Parameters:
- WAIT_CYCLES, 4, SRAM access cycles per transfer (>=2; SRAM read delay 30 ns at 20 ns clock period).
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- ADDR_W, 17, SRAM word-address width.
- DATA_W, 32, data width.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  reset, asynchronous, active-high.
- wr_en  in  1  store request from MEM stage.
- rd_en  in  1  load request from MEM stage.
- address  in  32  byte address from ALU result.
- write_data  in  DATA_W  store data (Rm value).
- read_data  out  DATA_W  load result, registered.
- ready  out  1  0 = freeze pipeline; 1 = MEM stage may advance.
- SRAM_ADDR  out  ADDR_W  SRAM word address.
- SRAM_WE_N  out  1  SRAM write enable, active-low.
- SRAM_DQ  inout  DATA_W  SRAM data bus.

Behaviour:
- Clock/reset: one clock, CLK; RST is asynchronous, active-high.
- Reset values: state IDLE, counter 0, latched op/address/data 0, read_data 0, SRAM_WE_N 1, SRAM_DQ Z, SRAM_ADDR 0. ready follows the IDLE rule.
- Address mapping: SRAM_ADDR = ((address - BASE_ADDR) >> 2) truncated to ADDR_W bits.
  - Subtraction is modulo 2^32.
  - Addresses below BASE_ADDR or beyond range wrap silently.
  - Bits [1:0] are ignored.
- States:
  - IDLE: ready = ~(rd_en | wr_en), combinational. On a request, latch op, mapped address and write_data, load counter with WAIT_CYCLES-1, and go to ACCESS.
  - ACCESS: ready = 0.
    - Write: SRAM_WE_N = 0 and SRAM_DQ driven with latched data for every ACCESS cycle.
    - Read: SRAM_WE_N = 1, SRAM_DQ = Z, and read_data <= SRAM_DQ on the cycle counter == 0.
    - Counter decrements each cycle. At 0, go to DONE.
  - DONE: ready = 1, SRAM_WE_N = 1, SRAM_DQ = Z. Unconditionally go to IDLE next cycle; the request still present in DONE is not re-accepted.
- SRAM_ADDR holds the latched address in ACCESS and DONE. In IDLE it shows the live mapped address.
- Timing: request first seen in cycle 0 (IDLE) gives ACCESS cycles 1..WAIT_CYCLES, then DONE in cycle WAIT_CYCLES+1. Total freeze is WAIT_CYCLES+1 cycles.
- read_data is valid from DONE onward and holds until the next read completes. Writes never modify read_data.
- Simultaneous rd_en & wr_en: write takes priority; no read performed.
- Inputs changing during ACCESS are ignored; only latched values are used.
- SRAM_DQ is never driven by this block when SRAM_WE_N = 1, so there is no bus contention.
- Reset mid-operation: immediate return to reset values. A partially performed write may have committed; read_data is cleared.

Decomposition:
- Shared package (arm_mem_pkg): state encoding IDLE/ACCESS/DONE, BASE_ADDR, SRAM ADDR_W/DATA_W constants.
- One sub-module: sram_wait_counter.
  - Load value, decrement-enable, zero flag.
  - Asynchronous active-high reset on RST.

Test Plan:
- Write: wr_en=1, address=1032, write_data=0xDEADBEEF from cycle 0.
  - SRAM_ADDR=2 and SRAM_WE_N=0 in cycles 1-4.
  - ready=0 in cycles 0-4 and 1 in cycle 5.
  - Memory word 2 = 0xDEADBEEF.
- Read-back: rd_en=1, address=1032.
  - SRAM_WE_N stays 1 and SRAM_DQ is not driven by the controller.
  - read_data=0xDEADBEEF in cycle 5, ready=1 in cycle 5, IDLE in cycle 6.
- Back-to-back: write 0x11111111 to 1024, then read 1024 with no idle gap.
  - Second request is accepted only in the IDLE after DONE; each access takes 5 frozen cycles plus 1 release cycle.
  - read_data=0x11111111.
- Priority and stability: rd_en=wr_en=1, address=1028, data=0xA5A5A5A5.
  - Write performed to word 1 and read_data unchanged.
  - Changing address to 2000 during ACCESS keeps SRAM_ADDR=1.
- Reset mid-read: assert RST asynchronously in ACCESS cycle 2.
  - Same instant: SRAM_WE_N=1, SRAM_DQ=Z, read_data=0, state IDLE.
  - ready=1 with no request pending.
- Address wrap and idle: address=1020 read gives SRAM_ADDR=0x1FFFF.
  - With no requests, ready stays 1 and SRAM_WE_N stays 1 indefinitely.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared constants and state encoding for the SRAM controller
package arm_mem_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Byte address of SRAM word 0 in the CPU address map
    localparam int SRAM_BASE_ADDR   = 1024;
    // External SRAM geometry
    localparam int SRAM_ADDR_W      = 17;
    localparam int SRAM_DATA_W      = 32;
    // Cycles each SRAM transfer is held on the bus (30 ns access at 20 ns clock)
    localparam int SRAM_WAIT_CYCLES = 4;

endpackage

// File: rtl/sram_wait_counter.sv
// rtl/sram_wait_counter.sv - loadable down-counter timing one SRAM access
import arm_mem_pkg::*;

module sram_wait_counter #(
    parameter int CNT_W = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Load has priority; decrement saturates at zero so a stray enable cannot wrap
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - MEM-stage to external SRAM bridge with pipeline freeze
import arm_mem_pkg::*;

module sram_controller #(
    parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES,
    parameter int BASE_ADDR   = SRAM_BASE_ADDR,
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DATA_W      = SRAM_DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [31:0]       address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              ready,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_WE_N,
    inout  wire  [DATA_W-1:0] SRAM_DQ
);

    localparam int CNT_W = $clog2(WAIT_CYCLES);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_op_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_read_data;

    logic                w_req;
    logic [31:0]         w_offset;
    logic [ADDR_W-1:0]   w_mapped;
    logic                w_cnt_load;
    logic                w_cnt_dec;
    logic                w_cnt_zero;
    logic                w_dq_oe;
    logic                w_unused_bits;

    assign w_req = rd_en | wr_en;

    // Byte address -> word address; subtraction wraps modulo 2^32 and the
    // result is truncated, so out-of-window addresses alias silently.
    assign w_offset      = address - 32'(BASE_ADDR);
    assign w_mapped      = w_offset[ADDR_W+1:2];
    assign w_unused_bits = ^{w_offset[31:ADDR_W+2], w_offset[1:0]};

    sram_wait_counter #(
        .CNT_W (CNT_W)
    ) u_wait_counter (
        .CLK        (CLK),
        .RST        (RST),
        .i_load     (w_cnt_load),
        .i_load_val (CNT_W'(WAIT_CYCLES - 1)),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; DONE always returns to IDLE so a held request is not re-accepted
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_req)      w_next_state = ST_ACCESS;
            ST_ACCESS: if (w_cnt_zero) w_next_state = ST_DONE;
            ST_DONE:                   w_next_state = ST_IDLE;
            default:                   w_next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; the bus is only driven while WE_N is low
    always_comb begin
        ready      = 1'b0;
        SRAM_WE_N  = 1'b1;
        w_dq_oe    = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_dec  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready      = ~w_req;
                w_cnt_load = w_req;
            end
            ST_ACCESS: begin
                SRAM_WE_N = ~r_op_write;
                w_dq_oe   = r_op_write;
                w_cnt_dec = 1'b1;
            end
            ST_DONE: begin
                ready = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    // Request capture and load-data register; inputs are ignored once latched
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_op_write  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_read_data <= '0;
        end else begin
            if (w_cnt_load) begin
                r_op_write <= wr_en;
                r_addr     <= w_mapped;
                r_wdata    <= write_data;
            end
            if ((r_state == ST_ACCESS) && !r_op_write && w_cnt_zero) begin
                r_read_data <= SRAM_DQ;
            end
        end
    end

    // IDLE presents the live mapped address so the SRAM can start decoding early
    assign SRAM_ADDR = RST ? '0 : ((r_state == ST_IDLE) ? w_mapped : r_addr);
    assign SRAM_DQ   = w_dq_oe ? r_wdata : {DATA_W{1'bz}};
    assign read_data = r_read_data;

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed table-driven bench for sram_controller
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [16:0] sram_addr;
    logic        sram_we_n;
    wire  [31:0] sram_dq;

    int n_pass  = 0;
    int n_total = 0;

    always #10 clk = ~clk;

    sram_controller dut (
        .CLK        (clk),
        .RST        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_DQ    (sram_dq)
    );

    // Small SRAM model: low address bits select one of 8 words
    logic [31:0] mem [0:7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hCAFEF00D};

    assign sram_dq = sram_we_n ? mem[sram_addr[2:0]] : 32'hzzzzzzzz;

    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr[2:0]] <= sram_dq;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [16:0] exp_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vec [7];

    initial begin
        vec[0] = '{1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 17'd2,       32'h00000000};
        vec[1] = '{1'b0, 1'b1, 32'd1032, 32'h0F0F0F0F, 17'd2,       32'hDEADBEEF};
        vec[2] = '{1'b1, 1'b0, 32'd1024, 32'h11111111, 17'd0,       32'hDEADBEEF};
        vec[3] = '{1'b0, 1'b1, 32'd1024, 32'h0F0F0F0F, 17'd0,       32'h11111111};
        vec[4] = '{1'b1, 1'b1, 32'd1028, 32'hA5A5A5A5, 17'd1,       32'h11111111};
        vec[5] = '{1'b0, 1'b1, 32'd1020, 32'h0F0F0F0F, 17'h1FFFF,   32'hCAFEF00D};
        vec[6] = '{1'b0, 1'b1, 32'd1028, 32'h0F0F0F0F, 17'd1,       32'hA5A5A5A5};

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'd1032; write_data = 32'h0;
        @(negedge clk);
        chk("reset read_data", read_data, 32'h0);
        chk("reset we_n", {31'b0, sram_we_n}, 32'd1);
        chk("reset ready", {31'b0, ready}, 32'd1);
        chk("reset sram_addr", {15'b0, sram_addr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Each vector is presented in an IDLE cycle directly after the previous DONE
        for (int v = 0; v < 7; v++) begin
            wr_en = vec[v].wr; rd_en = vec[v].rd;
            address = vec[v].addr; write_data = vec[v].wdata;
            @(negedge clk);
            chk($sformatf("v%0d c0 ready", v), {31'b0, ready}, 32'd0);
            chk($sformatf("v%0d c0 sram_addr", v), {15'b0, sram_addr}, {15'b0, vec[v].exp_addr});
            @(posedge clk); #1;
            address = 32'd2000; write_data = 32'h0BAD0BAD;
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                chk($sformatf("v%0d c%0d ready", v, c), {31'b0, ready}, 32'd0);
                chk($sformatf("v%0d c%0d sram_addr", v, c), {15'b0, sram_addr}, {15'b0, vec[v].exp_addr});
                chk($sformatf("v%0d c%0d we_n", v, c), {31'b0, sram_we_n}, {31'b0, ~vec[v].wr});
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk($sformatf("v%0d c5 ready", v), {31'b0, ready}, 32'd1);
            chk($sformatf("v%0d c5 we_n", v), {31'b0, sram_we_n}, 32'd1);
            chk($sformatf("v%0d c5 read_data", v), read_data, vec[v].exp_rdata);
            @(posedge clk); #1;
        end

        chk("mem word 0", mem[0], 32'h11111111);
        chk("mem word 1", mem[1], 32'hA5A5A5A5);
        chk("mem word 2", mem[2], 32'hDEADBEEF);
        chk("mem word 4 untouched", mem[4], 32'h0);

        // Idle: no requests keeps the pipeline free and the SRAM unwritten
        wr_en = 1'b0; rd_en = 1'b0; address = 32'd1032;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d ready", i), {31'b0, ready}, 32'd1);
            chk($sformatf("idle%0d we_n", i), {31'b0, sram_we_n}, 32'd1);
            @(posedge clk); #1;
        end

        // Reset asserted asynchronously in the middle of ACCESS cycle 2 of a read
        rd_en = 1'b1; address = 32'd1032;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #4 rst = 1'b1;
        #1;
        chk("rst mid we_n", {31'b0, sram_we_n}, 32'd1);
        chk("rst mid read_data", read_data, 32'h0);
        chk("rst mid sram_addr", {15'b0, sram_addr}, 32'd0);
        rd_en = 1'b0;
        #1;
        chk("rst mid ready", {31'b0, ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post rst ready", {31'b0, ready}, 32'd1);
        @(posedge clk); #1;

        // Controller recovers: a fresh read completes with the stored word
        rd_en = 1'b1; address = 32'd1032;
        repeat (5) @(posedge clk);
        #1;
        chk("recover c5 ready", {31'b0, ready}, 32'd1);
        chk("recover c5 read_data", read_data, 32'hDEADBEEF);
        @(posedge clk); #1;
        rd_en = 1'b0;
        @(negedge clk);
        chk("recover idle ready", {31'b0, ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
